// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
//   dmem_state_t : controller FSM states
//   WORD_W/BE_W  : data word width and number of byte lanes
//   WCNT_W       : wait-state counter width (WAIT_STATES up to 7)
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int WCNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Core data-port bundle between the core (master) and dmem_ctrl (slave).
//   data_address, write_data, byte_en, mem_read, mem_write : core -> ctrl
//   read_data, mem_stall, addr_err                         : ctrl -> core
interface dmem_ctrl_if;
  import dmem_pkg::*;

  logic [31:0]       data_address;
  logic [WORD_W-1:0] write_data;
  logic [BE_W-1:0]   byte_en;
  logic              mem_read;
  logic              mem_write;
  logic [WORD_W-1:0] read_data;
  logic              mem_stall;
  logic              addr_err;

  modport master (
    output data_address, write_data, byte_en, mem_read, mem_write,
    input  read_data, mem_stall, addr_err
  );

  modport slave (
    input  data_address, write_data, byte_en, mem_read, mem_write,
    output read_data, mem_stall, addr_err
  );

endinterface

// File: rtl/dmem_ctrl_sram_1p.sv
// Single-port word SRAM with byte-lane write enables and registered read data.
//   clk   : clock
//   en    : access enable for this cycle
//   we    : 1 = write (lanes selected by be), 0 = read into rdata
//   be    : byte-lane enables
//   addr  : word index
//   wdata : store data
//   rdata : read data, updated at the edge that ends a read cycle
// The array and rdata have no reset.
module sram_1p
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns the core's zero-latency data port into a
// wait-stated access to a single-port byte-enabled SRAM, stalling the core
// until each access completes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : core data port (slave side), see dmem_ctrl_if
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for mem_read/mem_write; latches request on arrival
// BUSY  | wcnt counts down; SRAM access issued when wcnt reaches 0
// RESP  | read_data/addr_err presented, stall released for one cycle
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_ctrl_if.slave  bus
);

  localparam int          ADDR_W    = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);

  dmem_state_t       state, state_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic [29:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              wr_q;
  logic              rd_valid_q;
  logic              err_q;

  logic              req;
  logic              in_range;
  logic              fire;
  logic [WORD_W-1:0] sram_rdata;
  logic              unused_addr_lsb;

  assign req             = bus.mem_read | bus.mem_write;
  assign in_range        = addr_q < DEPTH_IDX;
  assign unused_addr_lsb = ^bus.data_address[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    case (state)
      IDLE: if (req) state_nxt = BUSY;
      BUSY: begin
        if (wcnt == '0) begin
          fire      = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches and wait counter. rd_valid_q/err_q are set by the edge
  // that performs the SRAM access, so they are high exactly during RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      wr_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        addr_q  <= bus.data_address[31:2];
        wdata_q <= bus.write_data;
        be_q    <= bus.byte_en;
        wr_q    <= bus.mem_write;
        wcnt    <= WCNT_W'(WAIT_STATES);
      end else if (state == BUSY && wcnt != '0) begin
        wcnt <= wcnt - 1'b1;
      end
      rd_valid_q <= fire & ~wr_q & in_range;
      err_q      <= fire & ~in_range;
    end
  end

  sram_1p #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk   (clk),
    .en    (fire & in_range),
    .we    (wr_q),
    .be    (be_q),
    .addr  (addr_q[ADDR_W-1:0]),
    .wdata (wdata_q),
    .rdata (sram_rdata)
  );

  // rst_n gates the combinational IDLE term so a request held through reset
  // does not stall the core.
  assign bus.mem_stall = rst_n & (((state == IDLE) & req) | (state == BUSY));
  assign bus.read_data = rd_valid_q ? sram_rdata : '0;
  assign bus.addr_err  = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl. Four instances with WAIT_STATES
// 1, 0, 7 and 3 are driven one at a time; expected responses come from a
// small memory model and travel through a scoreboard queue.
module tb_dmem_ctrl;

  localparam int DEPTH = 1024;
  localparam int WS_TAB [4] = '{1, 0, 7, 3};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stall;
  } exp_t;

  logic        clk;
  logic        rst_v   [4];
  logic [31:0] addr_v  [4];
  logic [31:0] wd_v    [4];
  logic [3:0]  be_v    [4];
  logic        rd_v    [4];
  logic        wr_v    [4];
  logic [31:0] rdata_v [4];
  logic        stall_v [4];
  logic        err_v   [4];

  exp_t        sb [$];
  logic [31:0] mdl [int];
  int          n_chk  = 0;
  int          n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_ctrl_if ifc ();
    assign ifc.data_address = addr_v[g];
    assign ifc.write_data   = wd_v[g];
    assign ifc.byte_en      = be_v[g];
    assign ifc.mem_read     = rd_v[g];
    assign ifc.mem_write    = wr_v[g];
    assign rdata_v[g]       = ifc.read_data;
    assign stall_v[g]       = ifc.mem_stall;
    assign err_v[g]         = ifc.addr_err;

    dmem_ctrl #(
      .DEPTH_WORDS (DEPTH),
      .WAIT_STATES (WS_TAB[g])
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_v[g]),
      .bus   (ifc.slave)
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One complete access on instance d; holds the request until RESP.
  task automatic access(input int d, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
    exp_t        e, o;
    int          idx;
    int          key;
    int          n;
    logic [31:0] v;
    idx     = int'(addr >> 2);
    key     = d * 65536 + idx;
    e.stall = WS_TAB[d] + 2;
    e.err   = (idx >= DEPTH);
    e.rdata = 32'h0;
    if (!wr && !e.err) e.rdata = mdl.exists(key) ? mdl[key] : 32'h0;
    if (wr && !e.err) begin
      v = mdl.exists(key) ? mdl[key] : 32'h0;
      for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = wdata[8*i +: 8];
      mdl[key] = v;
    end
    sb.push_back(e);

    @(negedge clk);
    addr_v[d] = addr; wd_v[d] = wdata; be_v[d] = be;
    rd_v[d] = rd; wr_v[d] = wr;
    #1;
    n = 0;
    while (stall_v[d] && n < 20) begin
      n++;
      @(negedge clk); #1;
    end
    o = sb.pop_front();
    check($sformatf("stall d%0d a%h", d, addr), 32'(n), 32'(o.stall));
    check($sformatf("rdata d%0d a%h", d, addr), rdata_v[d], o.rdata);
    check($sformatf("err d%0d a%h", d, addr), 32'(err_v[d]), 32'(o.err));
    rd_v[d] = 1'b0; wr_v[d] = 1'b0;
    @(negedge clk); #1;
    check($sformatf("idle rdata d%0d", d), rdata_v[d], 32'h0);
    check($sformatf("idle err d%0d", d), 32'(err_v[d]), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_v[i] = 1'b0; addr_v[i] = '0; wd_v[i] = '0; be_v[i] = '0;
      rd_v[i] = 1'b0; wr_v[i] = 1'b0;
    end
    rd_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset stall", 32'(stall_v[0]), 32'h0);
    check("reset rdata", rdata_v[0], 32'h0);
    check("reset err", 32'(err_v[0]), 32'h0);
    rd_v[0] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) rst_v[i] = 1'b1;

    // WAIT_STATES=1: store/load, byte lanes, out of range, both requests
    access(0, 0, 1, 32'h0000_0000, 32'h0000_0000, 4'hF);
    access(0, 0, 1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF);
    access(0, 1, 0, 32'h0000_0040, 32'h0,         4'h0);
    access(0, 0, 1, 32'h0000_0080, 32'h1122_3344, 4'hF);
    access(0, 0, 1, 32'h0000_0080, 32'hAABB_CCDD, 4'h5);
    access(0, 1, 0, 32'h0000_0080, 32'h0,         4'h0);
    check("byte lanes model", mdl[32], 32'h11BB_33DD);
    access(0, 0, 1, 32'h0000_1000, 32'h1234_5678, 4'hF);
    access(0, 1, 0, 32'h0000_1000, 32'h0,         4'h0);
    access(0, 1, 0, 32'h0000_0000, 32'h0,         4'h0);
    access(0, 0, 1, 32'h0000_0084, 32'hFFFF_FFFF, 4'h0);
    access(0, 1, 0, 32'h0000_0084, 32'h0,         4'h0);
    access(0, 1, 1, 32'h0000_0010, 32'h5A5A_5A5A, 4'hF);
    access(0, 1, 0, 32'h0000_0010, 32'h0,         4'h0);

    // WAIT_STATES=0 and 7
    access(1, 0, 1, 32'h0000_0044, 32'h0F0F_1234, 4'hF);
    access(1, 1, 0, 32'h0000_0044, 32'h0,         4'h0);
    access(2, 0, 1, 32'h0000_0048, 32'h8765_4321, 4'hF);
    access(2, 1, 0, 32'h0000_0048, 32'h0,         4'h0);

    // WAIT_STATES=3: reset in the second BUSY cycle of a write
    access(3, 0, 1, 32'h0000_0020, 32'h0000_0000, 4'hF);
    @(negedge clk);
    addr_v[3] = 32'h20; wd_v[3] = 32'hCAFE_F00D; be_v[3] = 4'hF; wr_v[3] = 1'b1;
    #1;
    check("abort req stall", 32'(stall_v[3]), 32'h1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_v[3] = 1'b0;
    #1;
    check("abort stall", 32'(stall_v[3]), 32'h0);
    check("abort rdata", rdata_v[3], 32'h0);
    check("abort err", 32'(err_v[3]), 32'h0);
    @(negedge clk);
    wr_v[3] = 1'b0;
    @(negedge clk);
    rst_v[3] = 1'b1;
    access(3, 1, 0, 32'h0000_0020, 32'h0, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
